// File: rtl/mont_mul_responder.sv
// Bit-serial radix-2 Montgomery multiplier answering a start/done handshake: result = a*b*2^-NBITS mod m.
// Optional input checking (err port, early completion on bad operands) is enabled by MONT_MUL_ERRCHK_EN.
module mont_mul_responder #(
  parameter int WIDTH = 260,
  parameter int NBITS = 256
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] result,
  output logic             done
`ifdef MONT_MUL_ERRCHK_EN
  ,
  output logic             err
`endif
);

  localparam int CW = $clog2(NBITS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] ra_reg, ra_next;
  logic [WIDTH-1:0] rb_reg, rb_next;
  logic [WIDTH-1:0] rm_reg, rm_next;
  logic [WIDTH-1:0] s_reg, s_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             done_reg, done_next;
  logic [WIDTH:0]   t1, t2, diff;
  logic             bad_in;
  logic             err_q;

`ifdef MONT_MUL_ERRCHK_EN
  logic err_reg, err_next;

  assign bad_in = ~m[0] | (a >= m) | (b >= m);
  assign err_q  = err_reg;
  assign err    = err_reg;

  always_comb begin
    err_next = err_reg;
    if (state_reg == IDLE && start)
      err_next = bad_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_reg <= 1'b0;
    else          err_reg <= err_next;
  end
`else
  assign bad_in = 1'b0;
  assign err_q  = 1'b0;
`endif

  assign result = result_reg;
  assign done   = done_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = bad_in ? FIX : RUN;
      RUN:     if (cnt_reg == CW'(NBITS - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One Montgomery step per RUN cycle; sums carry one extra bit so S < 2m never overflows.
  always_comb begin
    ra_next     = ra_reg;
    rb_next     = rb_reg;
    rm_next     = rm_reg;
    s_next      = s_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    done_next   = done_reg;
    t1          = {1'b0, s_reg} + (rb_reg[0] ? {1'b0, ra_reg} : '0);
    t2          = t1 + (t1[0] ? {1'b0, rm_reg} : '0);
    diff        = {1'b0, s_reg} - {1'b0, rm_reg};
    case (state_reg)
      IDLE: begin
        done_next = ~start;
        if (start) begin
          ra_next  = a;
          rb_next  = b;
          rm_next  = m;
          s_next   = '0;
          cnt_next = '0;
        end
      end
      RUN: begin
        s_next   = WIDTH'(t2 >> 1);
        rb_next  = rb_reg >> 1;
        cnt_next = cnt_reg + CW'(1);
      end
      FIX: begin
        if (err_q)          result_next = '0;
        else if (!diff[WIDTH]) result_next = diff[WIDTH-1:0];
        else                result_next = s_reg;
        done_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ra_reg     <= '0;
      rb_reg     <= '0;
      rm_reg     <= '0;
      s_reg      <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      ra_reg     <= ra_next;
      rb_reg     <= rb_next;
      rm_reg     <= rm_next;
      s_reg      <= s_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      done_reg   <= done_next;
    end
  end

endmodule

// File: tb/tb_mont_mul_responder.sv
// Scoreboard bench for mont_mul_responder: a small (NBITS=8) and a default-size instance side by side.
module tb_mont_mul_responder;

  localparam int SW = 12, SN = 8, BW = 260, BN = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n_s = 1'b0, start_s = 1'b0, done_s, err_s;
  logic [SW-1:0] a_s = '0, b_s = '0, m_s = '0, result_s;
  logic          rst_n_b = 1'b0, start_b = 1'b0, done_b, err_b;
  logic [BW-1:0] a_b = '0, b_b = '0, m_b = '0, result_b;

  mont_mul_responder #(.WIDTH(SW), .NBITS(SN)) dut_s (
    .clk(clk), .reset_n(rst_n_s), .start(start_s), .a(a_s), .b(b_s), .m(m_s),
    .result(result_s), .done(done_s)
`ifdef MONT_MUL_ERRCHK_EN
    , .err(err_s)
`endif
  );

  mont_mul_responder #(.WIDTH(BW), .NBITS(BN)) dut_b (
    .clk(clk), .reset_n(rst_n_b), .start(start_b), .a(a_b), .b(b_b), .m(m_b),
    .result(result_b), .done(done_b)
`ifdef MONT_MUL_ERRCHK_EN
    , .err(err_b)
`endif
  );

`ifndef MONT_MUL_ERRCHK_EN
  assign err_s = 1'b0;
  assign err_b = 1'b0;
`endif

  typedef struct {
    logic [259:0] res;
    longint       due;
    bit           err;
  } exp_t;

  exp_t qs[$];
  exp_t qb[$];
  bit   skip_s = 1'b1, skip_b = 1'b1;
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input logic [259:0] act, input logic [259:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, req, cyc);
    end
  endtask

  // Reference: reduce the full product, then divide by 2 mod m NBITS times.
  function automatic logic [599:0] mont_ref(input logic [599:0] x, input logic [599:0] y,
                                            input logic [599:0] md, input int n);
    logic [599:0] p;
    p = (x * y) % md;
    for (int i = 0; i < n; i++) begin
      if (p[0]) p = p + md;
      p = p >> 1;
    end
    return p;
  endfunction

  function automatic logic [259:0] rand256();
    logic [259:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = (r << 32) | 260'($urandom());
    r[259:256] = '0;
    return r;
  endfunction

  task automatic monitor();
    logic done_s_d, done_b_d;
    exp_t e;
    done_s_d = 1'b0;
    done_b_d = 1'b0;
    forever begin
      @(negedge clk);
      if (done_s && !done_s_d) begin
        if (skip_s) skip_s = 1'b0;
        else if (qs.size() == 0) begin
          total++; bad++;
          $display("FAIL s_spurious_done actual=rise required=none cyc=%0d", cyc);
        end else begin
          e = qs.pop_front();
          chk("s_result", 260'(result_s), e.res);
          chk("s_latency", 260'(cyc), 260'(e.due));
`ifdef MONT_MUL_ERRCHK_EN
          chk("s_err", 260'(err_s), 260'(e.err));
`endif
          $display("small op done: result=%0d expected=%0d cyc=%0d", result_s, e.res, cyc);
        end
      end
      if (done_b && !done_b_d) begin
        if (skip_b) skip_b = 1'b0;
        else if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_spurious_done actual=rise required=none cyc=%0d", cyc);
        end else begin
          e = qb.pop_front();
          chk("b_result", result_b, e.res);
          chk("b_latency", 260'(cyc), 260'(e.due));
          $display("big op done: result=%0h cyc=%0d", result_b, cyc);
        end
      end
      done_s_d = done_s;
      done_b_d = done_b;
    end
  endtask

  task automatic wait_done_s();
    int n = 0;
    while (!done_s && n < 400) begin @(negedge clk); n++; end
    if (!done_s) begin
      total++; bad++;
      $display("FAIL s_timeout actual=busy required=done cyc=%0d", cyc);
    end
  endtask

  task automatic wait_done_b();
    int n = 0;
    while (!done_b && n < 400) begin @(negedge clk); n++; end
    if (!done_b) begin
      total++; bad++;
      $display("FAIL b_timeout actual=busy required=done cyc=%0d", cyc);
    end
  endtask

  task automatic op_s(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic [SW-1:0] md,
                      input logic [259:0] ex, input bit exerr, input int lat);
    wait_done_s();
    a_s = x; b_s = y; m_s = md; start_s = 1'b1;
    qs.push_back('{ex, cyc + lat + 1, exerr});
    @(negedge clk);
    start_s = 1'b0;
    chk("s_done_drop", 260'(done_s), 260'(0));
  endtask

  task automatic op_b(input logic [BW-1:0] x, input logic [BW-1:0] y, input logic [BW-1:0] md,
                      input logic [259:0] ex);
    wait_done_b();
    a_b = x; b_b = y; m_b = md; start_b = 1'b1;
    qb.push_back('{ex, cyc + BN + 2, 1'b0});
    @(negedge clk);
    start_b = 1'b0;
    chk("b_done_drop", 260'(done_b), 260'(0));
  endtask

  initial begin
    logic [SW-1:0] xs, ys, ms;
    logic [BW-1:0] xb, yb, mb;
    int lows;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("s_reset_done", 260'(done_s), 260'(0));
    chk("s_reset_result", 260'(result_s), 260'(0));
    chk("b_reset_done", 260'(done_b), 260'(0));
    chk("b_reset_result", result_b, 260'(0));
    rst_n_s = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);
    chk("s_done_after_reset", 260'(done_s), 260'(1));
    chk("b_done_after_reset", 260'(done_b), 260'(1));

    // Directed small cases, issued back to back as soon as done rises.
    op_s(12'd5, 12'd7, 12'd13, 260'd1, 1'b0, SN + 1);
    op_s(12'd12, 12'd12, 12'd13, 260'd3, 1'b0, SN + 1);
    op_s(12'd0, 12'd9, 12'd13, 260'd0, 1'b0, SN + 1);

    // Second start mid-operation must be ignored.
    op_s(12'd5, 12'd7, 12'd13, 260'd1, 1'b0, SN + 1);
    repeat (3) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_done_s();
    lows = 0;
    repeat (12) begin @(negedge clk); if (!done_s) lows++; end
    chk("s_no_restart", 260'(lows), 260'(0));

    for (int i = 0; i < 20; i++) begin
      ms = 12'($urandom_range(1, 127) * 2 + 1);
      xs = 12'($urandom_range(0, int'(ms) - 1));
      ys = 12'($urandom_range(0, int'(ms) - 1));
      op_s(xs, ys, ms, 260'(mont_ref(600'(xs), 600'(ys), 600'(ms), SN)), 1'b0, SN + 1);
    end

`ifdef MONT_MUL_ERRCHK_EN
    op_s(12'd5, 12'd7, 12'd12, 260'd0, 1'b1, 1);
    op_s(12'd5, 12'd7, 12'd13, 260'd1, 1'b0, SN + 1);
`endif

    // R mod m is a fixed point of Montgomery multiplication.
    mb = (260'd1 << 256) - 260'd189;
    op_b(260'd189, 260'd189, mb, 260'd189);

    for (int i = 0; i < 2; i++) begin
      mb = rand256() | 260'd1;
      xb = rand256() % mb;
      yb = rand256() % mb;
      op_b(xb, yb, mb, 260'(mont_ref(600'(xb), 600'(yb), 600'(mb), BN)));
      repeat (8) @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
    end

    // Asynchronous reset in the middle of a long operation.
    mb = rand256() | 260'd1;
    xb = rand256() % mb;
    yb = rand256() % mb;
    op_b(xb, yb, mb, 260'(mont_ref(600'(xb), 600'(yb), 600'(mb), BN)));
    repeat (98) @(negedge clk);
    #2;
    rst_n_b = 1'b0;
    skip_b = 1'b1;
    qb.delete();
    #1;
    chk("b_async_reset_done", 260'(done_b), 260'(0));
    chk("b_async_reset_result", result_b, 260'(0));
    @(negedge clk);
    rst_n_b = 1'b1;
    @(negedge clk);
    chk("b_done_after_release", 260'(done_b), 260'(1));

    mb = rand256() | 260'd1;
    xb = rand256() % mb;
    yb = rand256() % mb;
    op_b(xb, yb, mb, 260'(mont_ref(600'(xb), 600'(yb), 600'(mb), BN)));

    wait_done_s();
    wait_done_b();
    repeat (2) @(negedge clk);
    chk("queue_drain", 260'(qs.size() + qb.size()), 260'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
